// File: rtl/sweep_pkg.sv
// Shared definitions for the logic sweep checker: op encodings, FSM state
// type and the hold counter width.
package sweep_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    // HOLD is at most 255, so eight bits always cover the hold counter.
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        APPLY = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/sweep_ref_model.sv
// Combinational golden function: the value a correct gate of the selected
// type produces for the current stimulus vector.
module sweep_ref_model #(
    parameter int N = 3
) (
    input  logic [N-1:0] vec,
    input  logic [1:0]   op,
    output logic         expected
);
    import sweep_pkg::*;

    // Reduce the vector according to the latched op.
    always_comb begin
        expected = 1'b0;
        case (op)
            OP_AND:  expected = &vec;
            OP_OR:   expected = |vec;
            OP_XOR:  expected = ^vec;
            OP_NAND: expected = ~&vec;
            default: expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_sweep_checker.sv
// Exhaustive sweep tester for a small combinational gate: walks vec through
// every input combination, holds each for HOLD cycles, samples dut_y on one
// check cycle and counts mismatches against the reference function.
// Optional macro SWEEP_FIRST_ERR_EN enables capture of the first failing
// vector; without it first_err_vec/first_err_valid are tied to zero.
module logic_sweep_checker #(
    parameter int N    = 3,
    parameter int HOLD = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    output logic [N-1:0] vec,
    input  logic         dut_y,
    output logic         busy,
    output logic         done,
    output logic [N:0]   err_cnt,
    output logic [N-1:0] first_err_vec,
    output logic         first_err_valid
);
    import sweep_pkg::*;

    localparam logic [N-1:0]      VEC_MAX   = '1;
    localparam logic [N:0]        ERR_MAX   = {1'b1, {N{1'b0}}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        op_lat;
    logic              expected;
    logic              mismatch;
    logic              accept;

    sweep_ref_model #(.N(N)) u_ref (
        .vec      (vec),
        .op       (op_lat),
        .expected (expected)
    );

    // A start is only honoured when no sweep is in flight.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign mismatch = (dut_y != expected);

    // State register; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = APPLY;
            end
            APPLY: begin
                busy = 1'b1;
                if (hold_cnt == HOLD_LAST) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (vec == VEC_MAX) state_nxt = DONE;
                else                state_nxt = APPLY;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = APPLY;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Hold counter, vector counter, op latch and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec      <= '0;
            hold_cnt <= '0;
            op_lat   <= OP_AND;
            err_cnt  <= '0;
        end else if (accept) begin
            vec      <= '0;
            hold_cnt <= '0;
            op_lat   <= op;
            err_cnt  <= '0;
        end else begin
            case (state)
                APPLY: begin
                    if (hold_cnt == HOLD_LAST) hold_cnt <= '0;
                    else                       hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                CHECK: begin
                    // Saturating guard; 2^N mismatches is the ceiling anyway.
                    if (mismatch && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + (N+1)'(1);
                    if (vec != VEC_MAX) vec <= vec + N'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SWEEP_FIRST_ERR_EN
    // Latch the vector of the first mismatch seen in this sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (accept) begin
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if ((state == CHECK) && mismatch && !first_err_valid) begin
            first_err_vec   <= vec;
            first_err_valid <= 1'b1;
        end
    end
`else
    assign first_err_vec   = '0;
    assign first_err_valid = 1'b0;
`endif

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Bench for logic_sweep_checker: a cycle-count based model of the sweep
// predicts every output each cycle, with directed and randomized sweeps.
module tb_logic_sweep_checker;
    import sweep_pkg::*;

    localparam int N         = 3;
    localparam int H         = 5;
    localparam int NV        = 1 << N;
    localparam int PER       = H + 1;
    localparam int SWEEP_CYC = NV * PER;
`ifdef SWEEP_FIRST_ERR_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = OP_AND;
    logic [N-1:0]  vec;
    logic          dut_y;
    logic          busy, done;
    logic [N:0]    err_cnt;
    logic [N-1:0]  fvec;
    logic          fval;
    logic [NV-1:0] tt = '0;

    // Gate under test modelled as a truth table indexed by the stimulus.
    assign dut_y = tt[vec];

    logic_sweep_checker #(.N(N), .HOLD(H)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .vec(vec), .dut_y(dut_y),
        .busy(busy), .done(done), .err_cnt(err_cnt),
        .first_err_vec(fvec), .first_err_valid(fval)
    );

    logic       start2 = 1'b0;
    logic [1:0] op2 = OP_NAND;
    logic [1:0] vec2;
    logic       dut_y2, busy2, done2, fval2;
    logic [2:0] err2;
    logic [1:0] fvec2;
    logic [3:0] tt2 = 4'b0000;
    assign dut_y2 = tt2[vec2];

    logic_sweep_checker #(.N(2), .HOLD(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op(op2), .vec(vec2), .dut_y(dut_y2),
        .busy(busy2), .done(done2), .err_cnt(err2),
        .first_err_vec(fvec2), .first_err_valid(fval2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // What a correct gate of type o outputs for input value v.
    function automatic bit gold(input logic [1:0] o, input int v);
        case (o)
            OP_AND:  return v == NV - 1;
            OP_OR:   return v != 0;
            OP_XOR:  return ($countones(v) % 2) == 1;
            default: return v != NV - 1;
        endcase
    endfunction

    // Model: 0 idle, 1 running (m_k cycles since start), 2 done.
    int            m_phase = 0;
    int            m_k = 0;
    bit            m_ready = 1'b0;
    logic [1:0]    m_op = OP_AND;
    logic [NV-1:0] m_tt = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_ready = 1'b1;
        end else if (start && m_phase != 1) begin
            m_phase = 1;
            m_k = 0;
            m_op = op;
            m_tt = tt;
        end else if (m_phase == 1) begin
            m_k++;
            if (m_k == SWEEP_CYC) m_phase = 2;
        end
    end

    int c_nchk, c_err, c_first, c_vec;
    bit c_fv;

    always @(negedge clk) begin
        if (m_ready) begin
            case (m_phase)
                0:       begin c_nchk = 0;         c_vec = 0;        end
                1:       begin c_nchk = m_k / PER; c_vec = m_k / PER; end
                default: begin c_nchk = NV;        c_vec = NV - 1;   end
            endcase
            c_err = 0; c_first = 0; c_fv = 1'b0;
            for (int v = 0; v < c_nchk; v++) begin
                if (m_tt[v] != gold(m_op, v)) begin
                    c_err++;
                    if (!c_fv) begin c_fv = 1'b1; c_first = v; end
                end
            end
            if (!FE) begin c_fv = 1'b0; c_first = 0; end
            chk("cyc_vec",   32'(vec),     32'(c_vec));
            chk("cyc_busy",  32'(busy),    32'(m_phase == 1));
            chk("cyc_done",  32'(done),    32'(m_phase == 2));
            chk("cyc_err",   32'(err_cnt), 32'(c_err));
            chk("cyc_fval",  32'(fval),    32'(c_fv));
            chk("cyc_fvec",  32'(fvec),    32'(c_first));
        end
    end

    // Start a sweep and count busy cycles until done (bounded).
    task automatic run_sweep(input logic [1:0] o, input logic [NV-1:0] t, input bit scramble,
                             output int lat);
        op = o;
        tt = t;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < SWEEP_CYC + 20) begin
            if (busy) lat++;
            if (scramble) begin
                op = 2'($urandom);
                start = ($urandom_range(0, 7) == 0);
            end
            tick();
        end
        start = 1'b0;
        chk("sweep_latency", 32'(lat), 32'(SWEEP_CYC));
    endtask

    int lat;
    int t;
    bit saw_done;

    initial begin
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_vec",  32'(vec),     0);
        chk("rst_busy", 32'(busy),    0);
        chk("rst_done", 32'(done),    0);
        chk("rst_err",  32'(err_cnt), 0);
        chk("rst_fval", 32'(fval),    0);
        chk("rst_fvec", 32'(fvec),    0);

        // Small instance: N=2, HOLD=1, NAND against constant 0.
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 40) begin
            if (busy2) lat++;
            tick();
        end
        chk("n2_latency", 32'(lat),   8);
        chk("n2_err",     32'(err2),  3);
        chk("n2_fval",    32'(fval2), 32'(FE));
        chk("n2_fvec",    32'(fvec2), 0);

        // Correct 3-input AND.
        run_sweep(OP_AND, 8'b1000_0000, 1'b0, lat);
        chk("and_ok_err",  32'(err_cnt), 0);
        chk("and_ok_fval", 32'(fval),    0);
        chk("and_ok_vec",  32'(vec),     7);

        // AND expected, gate stuck at 0.
        run_sweep(OP_AND, 8'b0000_0000, 1'b0, lat);
        chk("stuck0_err",  32'(err_cnt), 1);
        chk("stuck0_fvec", 32'(fvec),    FE ? 7 : 0);
        chk("stuck0_fval", 32'(fval),    32'(FE));

        // XOR expected, AND gate present; op wiggled and start poked mid-sweep.
        run_sweep(OP_XOR, 8'b1000_0000, 1'b1, lat);
        chk("xor_and_err",  32'(err_cnt), 3);
        chk("xor_and_fvec", 32'(fvec),    FE ? 1 : 0);

        // Randomized sweeps; the per-cycle model does the checking.
        for (int i = 0; i < 12; i++) begin
            run_sweep(2'($urandom), NV'($urandom), 1'b1, lat);
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
        end

        // Start ignored while busy, then reset at vec=4 aborts the sweep.
        op = OP_OR;
        tt = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (vec != 3'd4 && t < 200) begin
            start = (t == 3);
            tick();
            t++;
        end
        start = 1'b0;
        chk("abort_reach_vec4", 32'(vec),     4);
        chk("abort_err_before", 32'(err_cnt), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_vec",  32'(vec),     0);
        chk("abort_busy", 32'(busy),    0);
        chk("abort_done", 32'(done),    0);
        chk("abort_err",  32'(err_cnt), 0);
        chk("abort_fval", 32'(fval),    0);
        chk("abort_fvec", 32'(fvec),    0);
        saw_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done || busy) saw_done = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(saw_done), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
